// File: rtl/sqrt_stream_if.sv
// sqrt_stream_if: radicand/tag in, root/remainder/tag out, each side valid/ready.
// slave: the root pipeline; master: the producer/consumer pair driving it.
interface sqrt_stream_if #(
  parameter int WIDTH_INPUT = 16,
  parameter int TAG_WIDTH   = 4
);
  localparam int WIDTH_OUTPUT = WIDTH_INPUT / 2 + WIDTH_INPUT % 2;

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH_INPUT-1:0]  radicand;
  logic [TAG_WIDTH-1:0]    in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH_OUTPUT-1:0] root;
  logic [WIDTH_OUTPUT:0]   remainder;
  logic [TAG_WIDTH-1:0]    out_tag;

  modport slave (
    input  in_valid, radicand, in_tag, out_ready,
    output in_ready, out_valid, root, remainder, out_tag
  );

  modport master (
    output in_valid, radicand, in_tag, out_ready,
    input  in_ready, out_valid, root, remainder, out_tag
  );
endinterface

// File: rtl/sqrt_stream.sv
// sqrt_stream: pipelined restoring integer sqrt, BITS_PER_STAGE root bits/stage.
// Ports: clk, rst_n (async low), bus (slave: radicand/tag in, root/rem/tag out).
module sqrt_stream #(
  parameter int WIDTH_INPUT    = 16,
  parameter int BITS_PER_STAGE = 1,
  parameter int TAG_WIDTH      = 4
) (
  input logic          clk,
  input logic          rst_n,
  sqrt_stream_if.slave bus
);
  localparam int WO = WIDTH_INPUT / 2 + WIDTH_INPUT % 2;
  localparam int L  = (WO + BITS_PER_STAGE - 1) / BITS_PER_STAGE;
  localparam int RW = WO + 2;
  localparam int XW = 2 * WO;

  logic [L-1:0]         vld;
  logic [L-1:0]         rdy;
  logic [L-1:0]         src_v;
  logic [WO-1:0]        rt  [L];
  logic [WO-1:0]        nrt [L];
  logic [RW-1:0]        rm  [L];
  logic [RW-1:0]        nrm [L];
  logic [XW-1:0]        rd  [L];
  logic [XW-1:0]        nrd [L];
  logic [TAG_WIDTH-1:0] tg  [L];
  logic [TAG_WIDTH-1:0] ntg [L];

  // A stage may load when some stage at or below it is empty,
  // or the consumer is taking the head result.
  always_comb begin : flow
    logic full;
    full = 1'b1;
    rdy  = '0;
    for (int k = 0; k < L; k++) begin
      full = 1'b1;
      for (int j = k; j < L; j++) begin
        full = full & vld[j];
      end
      rdy[k] = bus.out_ready | ~full;
    end
  end

  always_comb begin : datapath
    logic [WO-1:0] r;
    logic [RW-1:0] m;
    logic [XW-1:0] d;
    logic [RW+1:0] a;
    logic [RW+1:0] b;
    int            p;
    r = '0;
    m = '0;
    d = '0;
    a = '0;
    b = '0;
    p = 0;
    src_v = '0;
    for (int k = 0; k < L; k++) begin
      p = (k > 0) ? k - 1 : 0;
      if (k == 0) begin
        r = '0;
        m = '0;
        d = '0;
        d[WIDTH_INPUT-1:0] = bus.radicand;
        src_v[k] = bus.in_valid;
        ntg[k]   = bus.in_tag;
      end else begin
        r = rt[p];
        m = rm[p];
        d = rd[p];
        src_v[k] = vld[p];
        ntg[k]   = tg[p];
      end
      // Last stage stops once all WO root bits are resolved.
      for (int j = 0; j < BITS_PER_STAGE; j++) begin
        if (k * BITS_PER_STAGE + j < WO) begin
          a = {m, d[XW-1 -: 2]};
          b = {2'b00, r, 2'b01};
          r = r << 1;
          if (a >= b) begin
            m    = RW'(a - b);
            r[0] = 1'b1;
          end else begin
            m = RW'(a);
          end
          d = d << 2;
        end
      end
      nrt[k] = r;
      nrm[k] = m;
      nrd[k] = d;
    end
  end

  // Data only moves with a valid word, so the outputs stay
  // at zero after reset until the first result lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int k = 0; k < L; k++) begin
        rt[k] <= '0;
        rm[k] <= '0;
        rd[k] <= '0;
        tg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < L; k++) begin
        if (rdy[k]) begin
          vld[k] <= src_v[k];
          if (src_v[k]) begin
            rt[k] <= nrt[k];
            rm[k] <= nrm[k];
            rd[k] <= nrd[k];
            tg[k] <= ntg[k];
          end
        end
      end
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld[L-1];
  assign bus.root      = rt[L-1];
  assign bus.remainder = rm[L-1][WO:0];
  assign bus.out_tag   = tg[L-1];
endmodule

// File: tb/tb_sqrt_stream.sv
// tb_sqrt_stream: directed and randomized checks of sqrt_stream.
// Several widths/stage splits run against hand values and a brute-force sqrt.
module tb_sqrt_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  bit go_rnd = 1'b0;

  always #5 clk = ~clk;

  sqrt_stream_if #(.WIDTH_INPUT(16), .TAG_WIDTH(4)) ba ();
  sqrt_stream_if #(.WIDTH_INPUT(9), .TAG_WIDTH(4)) bb ();
  sqrt_stream_if #(.WIDTH_INPUT(16), .TAG_WIDTH(4)) bc ();

  sqrt_stream #(
    .WIDTH_INPUT(16), .BITS_PER_STAGE(1), .TAG_WIDTH(4)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));

  sqrt_stream #(
    .WIDTH_INPUT(9), .BITS_PER_STAGE(1), .TAG_WIDTH(4)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));

  sqrt_stream #(
    .WIDTH_INPUT(16), .BITS_PER_STAGE(3), .TAG_WIDTH(4)
  ) dut_c (.clk(clk), .rst_n(rst_n), .bus(bc));

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] isqrt(input logic [63:0] x);
    logic [63:0] r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r = r + 1;
    return r;
  endfunction

  task automatic t_stream();
    logic [15:0] xs [4];
    logic [7:0]  rts [4];
    logic [8:0]  rms [4];
    bit          ev;
    xs  = '{16'd0, 16'd144, 16'd143, 16'd65535};
    rts = '{8'd0, 8'd12, 8'd11, 8'd255};
    rms = '{9'd0, 9'd0, 9'd22, 9'd510};
    ba.out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      ev = (c >= 8 && c <= 11);
      check("strm_v", 64'(ba.out_valid), 64'(ev));
      if (ev) begin
        check("strm_root", 64'(ba.root), 64'(rts[c-8]));
        check("strm_rem", 64'(ba.remainder), 64'(rms[c-8]));
        check("strm_tag", 64'(ba.out_tag), 64'(c - 7));
      end
      ba.in_valid = (c < 4);
      if (c < 4) begin
        ba.radicand = xs[c];
        ba.in_tag   = 4'(c + 1);
      end
    end
    ba.in_valid = 1'b0;
  endtask

  task automatic t_bp();
    int idx;
    int k;
    bit ev;
    idx = 0;
    ba.out_ready = 1'b1;
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      ev = (c >= 8 && c <= 24);
      k  = (c <= 13) ? 0 : c - 13;
      check("bp_v", 64'(ba.out_valid), 64'(ev));
      if (ev) begin
        check("bp_root", 64'(ba.root), 64'(k + 100));
        check("bp_rem", 64'(ba.remainder), 64'(k));
        check("bp_tag", 64'(ba.out_tag), 64'(k));
      end
      ba.out_ready = !(c >= 8 && c <= 12);
      ba.in_valid  = (idx < 12);
      ba.radicand  = 16'((idx + 100) * (idx + 100) + idx);
      ba.in_tag    = 4'(idx);
      #1;
      check("bp_rdy", 64'(ba.in_ready), 64'(!(c >= 8 && c <= 12)));
      if (ba.in_valid && ba.in_ready) idx++;
    end
    ba.in_valid = 1'b0;
    check("bp_cnt", 64'(idx), 12);
  endtask

  task automatic t_bubble();
    logic [63:0] qx [$];
    logic [3:0]  qt [$];
    logic [63:0] x;
    int sent;
    int got;
    int extra;
    bit acc;
    sent = 0;
    got = 0;
    extra = 0;
    acc = 1'b0;
    for (int c = 0; c < 200 && got < 16; c++) begin
      @(negedge clk);
      if (!(ba.in_valid && !acc)) begin
        ba.in_valid = (sent < 16) && (c % 2 == 0);
        ba.radicand = 16'($urandom);
        ba.in_tag   = 4'(sent);
      end
      ba.out_ready = (c % 2 == 1);
      #1;
      acc = ba.in_valid && ba.in_ready;
      if (acc) begin
        qx.push_back(64'(ba.radicand));
        qt.push_back(ba.in_tag);
        sent++;
      end
      if (ba.out_valid && ba.out_ready) begin
        if (qx.size() == 0) begin
          check("bub_extra", 1, 0);
        end else begin
          x = qx.pop_front();
          check("bub_root", 64'(ba.root), isqrt(x));
          check("bub_rem", 64'(ba.remainder), x - isqrt(x) * isqrt(x));
          check("bub_tag", 64'(ba.out_tag), 64'(qt.pop_front()));
        end
        got++;
      end
    end
    ba.in_valid  = 1'b0;
    ba.out_ready = 1'b1;
    check("bub_cnt", 64'(got), 16);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ba.out_valid) extra++;
    end
    check("bub_dup", 64'(extra), 0);
  endtask

  task automatic t_reset();
    logic [15:0] xs [4];
    int stale;
    xs = '{16'd40000, 16'd10000, 16'd2500, 16'd625};
    stale = 0;
    ba.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ba.in_valid = 1'b1;
      ba.radicand = xs[c];
      ba.in_tag   = 4'(c + 6);
    end
    @(negedge clk);
    ba.in_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_pre_v", 64'(ba.out_valid), 1);
    check("rst_pre_root", 64'(ba.root), 200);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_v", 64'(ba.out_valid), 0);
    check("rst_async_root", 64'(ba.root), 0);
    check("rst_async_rem", 64'(ba.remainder), 0);
    check("rst_async_tag", 64'(ba.out_tag), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ba.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ba.out_valid) stale++;
    end
    check("rst_stale", 64'(stale), 0);
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      check("rst_81_v", 64'(ba.out_valid), 64'(c == 8));
      if (c == 8) begin
        check("rst_81_root", 64'(ba.root), 9);
        check("rst_81_rem", 64'(ba.remainder), 0);
      end
      ba.in_valid = (c == 0);
      ba.radicand = 16'd81;
      ba.in_tag   = 4'd3;
    end
    ba.in_valid = 1'b0;
  endtask

  task automatic t_small();
    bb.out_ready = 1'b1;
    bc.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("w9_v", 64'(bb.out_valid), 64'(c == 5 || c == 6));
      if (c == 5) begin
        check("w9_root", 64'(bb.root), 22);
        check("w9_rem", 64'(bb.remainder), 27);
      end
      if (c == 6) begin
        check("w9_root", 64'(bb.root), 16);
        check("w9_rem", 64'(bb.remainder), 0);
      end
      check("bps3_v", 64'(bc.out_valid), 64'(c == 3 || c == 4));
      if (c == 3) begin
        check("bps3_root", 64'(bc.root), 200);
        check("bps3_rem", 64'(bc.remainder), 0);
      end
      if (c == 4) begin
        check("bps3_root", 64'(bc.root), 255);
        check("bps3_rem", 64'(bc.remainder), 510);
      end
      bb.in_valid = (c < 2);
      bb.radicand = (c == 0) ? 9'd511 : 9'd256;
      bc.in_valid = (c < 2);
      bc.radicand = (c == 0) ? 16'd40000 : 16'd65535;
    end
    bb.in_valid = 1'b0;
    bc.in_valid = 1'b0;
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int W = (g == 0) ? 8 : (g == 1) ? 15 : 32;
    localparam int B = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    localparam int N = 3334;
    sqrt_stream_if #(.WIDTH_INPUT(W), .TAG_WIDTH(4)) bus ();
    sqrt_stream #(
      .WIDTH_INPUT(W), .BITS_PER_STAGE(B), .TAG_WIDTH(4)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    bit done = 1'b0;

    initial begin : drive
      logic [63:0] qx [$];
      logic [3:0]  qt [$];
      logic [63:0] x;
      logic [63:0] r;
      int sent;
      int got;
      bit acc;
      sent = 0;
      got = 0;
      acc = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.radicand  = '0;
      bus.in_tag    = '0;
      wait (go_rnd);
      for (int c = 0; c < 20000 && got < N; c++) begin
        @(negedge clk);
        if (!(bus.in_valid && !acc)) begin
          bus.in_valid = (sent < N) && ($urandom_range(3) != 0);
          bus.radicand = W'($urandom);
          if ($urandom_range(15) == 0) bus.radicand = '1;
          bus.in_tag = 4'($urandom);
        end
        bus.out_ready = ($urandom_range(3) != 0);
        #1;
        acc = bus.in_valid && bus.in_ready;
        if (acc) begin
          qx.push_back(64'(bus.radicand));
          qt.push_back(bus.in_tag);
          sent++;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (qx.size() == 0) begin
            check("rnd_extra", 1, 0);
          end else begin
            x = qx.pop_front();
            r = 64'(bus.root);
            check("rnd_lo", 64'(r * r <= x), 1);
            check("rnd_hi", 64'((r + 1) * (r + 1) > x), 1);
            check("rnd_rem", 64'(bus.remainder), x - r * r);
            check("rnd_tag", 64'(bus.out_tag), 64'(qt.pop_front()));
          end
          got++;
        end
      end
      bus.in_valid = 1'b0;
      check("rnd_cnt", 64'(got), 64'(N));
      done = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    bit all;
    ba.in_valid = 1'b0; ba.radicand = '0; ba.in_tag = '0; ba.out_ready = 1'b0;
    bb.in_valid = 1'b0; bb.radicand = '0; bb.in_tag = '0; bb.out_ready = 1'b0;
    bc.in_valid = 1'b0; bc.radicand = '0; bc.in_tag = '0; bc.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_v", 64'(ba.out_valid), 0);
    check("rst_root", 64'(ba.root), 0);
    check("rst_rem", 64'(ba.remainder), 0);
    check("rst_tag", 64'(ba.out_tag), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rdy", 64'(ba.in_ready), 1);
    t_stream();
    t_bp();
    t_bubble();
    t_reset();
    t_small();
    go_rnd = 1'b1;
    all = 1'b0;
    for (int i = 0; i < 30000 && !all; i++) begin
      @(negedge clk);
      all = g_rnd[0].done && g_rnd[1].done && g_rnd[2].done;
    end
    check("rnd_done", 64'(all), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
